icache_refill_ctrl: RTL
=======================

Name: icache_refill_ctrl

Overview:
- Direct-mapped instruction cache controller between the fetch stage and backing instruction memory.
- Holds tag/valid/data arrays and serves fetch requests: hits in 1 cycle, misses by sequencing a line refill over a valid/ready request + beat-stream response interface.
- Provides a single-cycle whole-cache flush (for fence.i).
- Returns NONE_INST whenever no valid response is presented.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, instruction/word width
NONE_INST, 0, value driven on resp_inst when resp_valid=0
NUM_LINES, 16, cache lines (power of two, >=2)
LINE_WORDS, 4, words per line (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  fetch request valid
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
resp_valid  out  1  instruction valid this cycle (1-cycle pulse, no backpressure)
resp_inst  out  DATA_WIDTH  instruction; NONE_INST when resp_valid=0
flush  in  1  invalidate all lines
mem_req_valid  out  1  refill request valid
mem_req_ready  in  1  memory accepts refill request
mem_req_addr  out  ADDR_WIDTH  line-aligned refill address (offset and [1:0] zero)
mem_resp_valid  in  1  refill data beat valid
mem_resp_data  in  DATA_WIDTH  refill beat, word 0 first

Behaviour:
- Address split: word offset = addr[OW+1:2], OW=log2(LINE_WORDS); index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Reset: state=IDLE, all valid bits=0, beat counter=0, req_ready=1, resp_valid=0, resp_inst=NONE_INST, mem_req_valid=0, mem_req_addr=0. Data/tag arrays are not reset.
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE:
  - req_ready=1 unless flush=1.
  - On req_valid&req_ready, latch req_addr and go to LOOKUP.
  - flush=1 in IDLE: clear all valid bits that cycle, accept no request.
- LOOKUP:
  - Hit (valid[index] && tag match): resp_valid=1, resp_inst=data[index][offset] in this same cycle, then go to IDLE. Hit latency is 1 cycle after acceptance; throughput is one request per 2 cycles.
  - Miss: go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr = latched addr with offset and [1:0] cleared; held stable until mem_req_ready.
  - Handshake completes on the cycle mem_req_valid&mem_req_ready; then go to REFILL with counter=0.
- REFILL:
  - Each mem_resp_valid beat writes data[index][counter] and increments counter.
  - On the beat where counter==LINE_WORDS-1: write tag[index]; set valid[index]=1 unless a flush occurred during this miss; go to RESP.
  - The requested word is captured into a response register as it streams by.
  - Gaps between beats are allowed.
- RESP: resp_valid=1, resp_inst=captured word for one cycle, then go to IDLE.
- mem_resp_valid outside REFILL is ignored.
- flush outside IDLE:
  - Clears all valid bits immediately.
  - Sets a sticky flag so an in-flight refill does not mark its line valid.
  - The in-flight request still completes and responds with the fetched word.
  - Flag clears on return to IDLE.
- Reset mid-operation (any state): immediate return to reset values; pending refill abandoned; its later beats ignored.
- req_ready=0 in every state except IDLE.
- The requested address is latched at acceptance, so req_addr changes after acceptance have no effect.

Test Plan:
- Cold miss: reset, req 0x0000_0008 -> mem_req_addr=0x0000_0000 handshake; beats 0xA0,0xA1,0xA2,0xA3 -> resp_valid 1 cycle after last beat with resp_inst=0xA2; line valid.
- Hit: then req 0x0000_000C -> no mem_req_valid; resp_valid at cycle after acceptance with resp_inst=0xA3; resp_inst=NONE_INST on the other cycles.
- Conflict eviction: req 0x0000_0100 (same index 0 with defaults, different tag) -> refill from 0x100; a subsequent req 0x0000_0000 misses again.
- Backpressure/gaps: hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stable; insert 2-cycle gaps between beats -> data still correct.
- Flush during refill: flush asserted while in REFILL -> response still correct; rerequest of same address misses. Flush in IDLE -> req_ready=0 that cycle, all lines invalid afterwards.
- Reset mid-refill after 2 beats: assert reset -> outputs at reset values next cycle; stray beats ignored; next req to same line misses and refills cleanly.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache: single-cycle hits, line refill over a request/beat-stream
// memory port, and whole-cache flush for fence.i.
module icache_refill_ctrl #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NONE_INST  = '0,
   parameter int                    NUM_LINES  = 16,
   parameter int                    LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_inst,
   input  logic                  flush,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data
);
   localparam int OW = $clog2(LINE_WORDS);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = ADDR_WIDTH - OW - IW - 2;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_RESP} state_t;

   state_t                r_state, w_state_next;
   logic [ADDR_WIDTH-3:0] r_addr;
   logic [NUM_LINES-1:0]  r_valid, w_valid_next;
   logic [OW-1:0]         r_cnt;
   logic                  r_flushed;
   logic [TW-1:0]         r_tag_mem [NUM_LINES];
   logic [DATA_WIDTH-1:0] r_data_mem [NUM_LINES*LINE_WORDS];
   logic [TW-1:0]         r_rd_tag;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [DATA_WIDTH-1:0] r_resp_data;

   logic          w_accept, w_hit, w_beat, w_fill_done;
   logic [IW-1:0] w_idx, w_req_idx;
   logic [OW-1:0] w_off, w_req_off;
   logic [TW-1:0] w_tag;
   logic          w_unused;

   // r_addr holds the word address; byte-offset bits never matter for fetch
   assign w_off     = r_addr[OW-1:0];
   assign w_idx     = r_addr[OW+IW-1:OW];
   assign w_tag     = r_addr[ADDR_WIDTH-3:OW+IW];
   assign w_req_off = req_addr[OW+1:2];
   assign w_req_idx = req_addr[OW+IW+1:OW+2];
   assign w_hit     = r_valid[w_idx] && (r_rd_tag == w_tag);
   assign w_unused  = ^req_addr[1:0];

   always_comb begin
      w_state_next  = r_state;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_inst     = NONE_INST;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      w_accept      = 1'b0;
      w_beat        = 1'b0;
      w_fill_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = !flush;
            w_accept  = req_valid && !flush;
            if (w_accept) w_state_next = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (w_hit) begin
               resp_valid   = 1'b1;
               resp_inst    = r_rd_data;
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_MISS_REQ;
            end
         end
         S_MISS_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {r_addr[ADDR_WIDTH-3:OW], {(OW+2){1'b0}}};
            if (mem_req_ready) w_state_next = S_REFILL;
         end
         S_REFILL: begin
            if (mem_resp_valid) begin
               w_beat = 1'b1;
               if (r_cnt == OW'(LINE_WORDS-1)) begin
                  w_fill_done  = 1'b1;
                  w_state_next = S_RESP;
               end
            end
         end
         S_RESP: begin
            resp_valid   = 1'b1;
            resp_inst    = r_resp_data;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Flush wins over a completing refill, including one finishing in the flush cycle
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
         assign w_valid_next[gi] = flush ? 1'b0 :
                                   (w_fill_done && !r_flushed && w_idx == IW'(gi)) ? 1'b1 :
                                   r_valid[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_valid   <= '0;
         r_cnt     <= '0;
         r_flushed <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_valid   <= w_valid_next;
         r_flushed <= (w_state_next == S_IDLE) ? 1'b0 : (r_flushed | flush);
         if (r_state == S_MISS_REQ) r_cnt <= '0;
         else if (w_beat)           r_cnt <= r_cnt + OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr    <= req_addr[ADDR_WIDTH-1:2];
         r_rd_data <= r_data_mem[{w_req_idx, w_req_off}];
         r_rd_tag  <= r_tag_mem[w_req_idx];
      end
      if (w_beat && r_cnt == w_off) r_resp_data <= mem_resp_data;
   end

   always_ff @(posedge clk) begin
      if (w_beat) r_data_mem[{w_idx, r_cnt}] <= mem_resp_data;
   end

   always_ff @(posedge clk) begin
      if (w_fill_done) r_tag_mem[w_idx] <= w_tag;
   end
endmodule
